// File: rtl/top_pkg.sv
// Shared defaults and FSM state encoding for the input/weight router.
// Optional feature macro: TOP_ADDR_CHECK_EN (input address range check).
package top_pkg;
    localparam int SRAM_DATA_WIDTH = 64;
    localparam int ADDR_WIDTH      = 8;

    typedef enum logic [1:0] {
        IDLE,
        ROUTE,
        DONE
    } state_t;
endpackage

// File: rtl/sram_1w1r.sv
// Simple dual-port SRAM: synchronous write, registered read.
// Optional feature macro: none (see top.sv for TOP_ADDR_CHECK_EN).
module sram_1w1r #(
    parameter int DATA_WIDTH = top_pkg::SRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = top_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Non-blocking read of the old word on a same-address write.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/top.sv
// Convolution window router: streams input/weight SRAM word pairs.
// Optional feature macro: TOP_ADDR_CHECK_EN (zero out-of-range input beats).
module top #(
    parameter int SRAM_DATA_WIDTH = top_pkg::SRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH      = top_pkg::ADDR_WIDTH
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic                       i_reg_clear,
    input  logic [SRAM_DATA_WIDTH-1:0] i_data_in,
    input  logic [ADDR_WIDTH-1:0]      i_write_addr,
    input  logic [1:0]                 i_sram_select,
    input  logic                       i_write_en,
    input  logic                       i_route_en,
    input  logic [ADDR_WIDTH-1:0]      i_i_start_addr,
    input  logic [ADDR_WIDTH-1:0]      i_i_addr_end,
    input  logic [ADDR_WIDTH-1:0]      i_i_size,
    input  logic [ADDR_WIDTH-1:0]      i_o_size,
    input  logic [ADDR_WIDTH-1:0]      i_stride,
    input  logic [ADDR_WIDTH-1:0]      i_w_start_addr,
    input  logic [ADDR_WIDTH-1:0]      i_w_addr_offset,
    input  logic [ADDR_WIDTH-1:0]      i_route_size,
    output logic [SRAM_DATA_WIDTH-1:0] o_i_data,
    output logic [SRAM_DATA_WIDTH-1:0] o_w_data,
    output logic                       o_valid,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_oob
);
    import top_pkg::*;

    state_t state, state_n;

    logic [ADDR_WIDTH-1:0] i_start_q, i_end_q, i_size_q;
    logic [ADDR_WIDTH-1:0] o_size_q, stride_q, ksz_q;
    logic [ADDR_WIDTH-1:0] w_start_q, w_off_q, rs_q;
    logic [ADDR_WIDTH-1:0] ox, oy, k, kr, kc;
    logic [ADDR_WIDTH-1:0] row, col, i_addr, w_addr;
    logic [SRAM_DATA_WIDTH-1:0] i_rd, w_rd;
    logic armed, start, empty, last;
    logic valid_q, done_q;

    assign start = (state == IDLE) && i_route_en && armed && !i_reg_clear;
    assign empty = (i_o_size == '0) || (i_route_size == '0);
    assign last  = (k == rs_q - 1'b1) &&
                   (ox == o_size_q - 1'b1) &&
                   (oy == o_size_q - 1'b1);

    assign row    = oy * stride_q + kr;
    assign col    = ox * stride_q + kc;
    assign i_addr = i_start_q + row * i_size_q + col;
    assign w_addr = w_start_q + k * w_off_q;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = empty ? DONE : ROUTE;
            ROUTE:   if (last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (i_reg_clear) state_n = IDLE;
    end

    // A new route needs i_route_en seen low while idle.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)                              armed <= 1'b1;
        else if (start)                           armed <= 1'b0;
        else if (state == IDLE && !i_route_en)    armed <= 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            i_start_q <= '0;
            i_end_q   <= '0;
            i_size_q  <= '0;
            o_size_q  <= '0;
            stride_q  <= '0;
            ksz_q     <= '0;
            w_start_q <= '0;
            w_off_q   <= '0;
            rs_q      <= '0;
        end else if (start) begin
            i_start_q <= i_i_start_addr;
            i_end_q   <= i_i_addr_end;
            i_size_q  <= i_i_size;
            o_size_q  <= i_o_size;
            stride_q  <= i_stride;
            ksz_q     <= i_i_size - (i_o_size - 1'b1) * i_stride;
            w_start_q <= i_w_start_addr;
            w_off_q   <= i_w_addr_offset;
            rs_q      <= i_route_size;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            {ox, oy, k, kr, kc} <= '0;
        end else if (i_reg_clear || state != ROUTE) begin
            {ox, oy, k, kr, kc} <= '0;
        end else if (k == rs_q - 1'b1) begin
            k  <= '0;
            kr <= '0;
            kc <= '0;
            if (ox == o_size_q - 1'b1) begin
                ox <= '0;
                oy <= oy + 1'b1;
            end else begin
                ox <= ox + 1'b1;
            end
        end else begin
            k <= k + 1'b1;
            if (kc == ksz_q - 1'b1) begin
                kc <= '0;
                kr <= kr + 1'b1;
            end else begin
                kc <= kc + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (i_reg_clear) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= (state == ROUTE);
            done_q  <= (start && empty) || (state == ROUTE && last);
        end
    end

`ifdef TOP_ADDR_CHECK_EN
    logic oob_q;
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)          oob_q <= 1'b0;
        else if (i_reg_clear) oob_q <= 1'b0;
        else                  oob_q <= (state == ROUTE) && (i_addr > i_end_q);
    end
`else
    logic oob_q;
    logic unused_end;
    assign oob_q      = 1'b0;
    assign unused_end = ^i_end_q;
`endif

    sram_1w1r #(
        .DATA_WIDTH(SRAM_DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_w_sram (
        .clk  (i_clk),
        .we   (i_write_en && i_sram_select == 2'd0),
        .waddr(i_write_addr),
        .wdata(i_data_in),
        .raddr(w_addr),
        .rdata(w_rd)
    );

    sram_1w1r #(
        .DATA_WIDTH(SRAM_DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_i_sram (
        .clk  (i_clk),
        .we   (i_write_en && i_sram_select == 2'd1),
        .waddr(i_write_addr),
        .wdata(i_data_in),
        .raddr(i_addr),
        .rdata(i_rd)
    );

    assign o_valid  = valid_q;
    assign o_done   = done_q;
    assign o_busy   = (state != IDLE);
    assign o_oob    = oob_q;
    assign o_w_data = valid_q ? w_rd : '0;
    assign o_i_data = (valid_q && !oob_q) ? i_rd : '0;
endmodule

// File: tb/tb_top.sv
// Scoreboard bench for the router: directed routes, clear, reset, re-arm.
// Honours TOP_ADDR_CHECK_EN for out-of-range expectations.
module tb_top;
    localparam int DW = 64;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          reg_clear = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [AW-1:0] write_addr = '0;
    logic [1:0]    sram_select = 2'd3;
    logic          write_en = 1'b0;
    logic          route_en = 1'b0;
    logic [AW-1:0] i_start = '0, i_end = '0, i_size = '0, o_size = '0;
    logic [AW-1:0] stride = '0, w_start = '0, w_off = '0, route_size = '0;
    logic [DW-1:0] o_i_data, o_w_data;
    logic          o_valid, o_busy, o_done, o_oob;

    always #5 clk = ~clk;

    top dut (
        .i_clk          (clk),
        .i_nrst         (rst_n),
        .i_reg_clear    (reg_clear),
        .i_data_in      (data_in),
        .i_write_addr   (write_addr),
        .i_sram_select  (sram_select),
        .i_write_en     (write_en),
        .i_route_en     (route_en),
        .i_i_start_addr (i_start),
        .i_i_addr_end   (i_end),
        .i_i_size       (i_size),
        .i_o_size       (o_size),
        .i_stride       (stride),
        .i_w_start_addr (w_start),
        .i_w_addr_offset(w_off),
        .i_route_size   (route_size),
        .o_i_data       (o_i_data),
        .o_w_data       (o_w_data),
        .o_valid        (o_valid),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_oob          (o_oob)
    );

    typedef struct {
        logic [DW-1:0] i;
        logic [DW-1:0] w;
        logic          oob;
    } beat_t;

    beat_t         exp_q[$];
    beat_t         e;
    logic [DW-1:0] cap_i[$];
    logic [DW-1:0] cap_w[$];
    logic [DW-1:0] mi [0:255];
    logic [DW-1:0] mw [0:255];
    int checks = 0;
    int failures = 0;
    int beats = 0;
    int done_cnt = 0;

    function automatic logic [DW-1:0] word(input int a);
        logic [7:0] b;
        b = 8'(a);
        return {8{b}};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid) begin
                beats++;
                cap_i.push_back(o_i_data);
                cap_w.push_back(o_w_data);
                if (exp_q.size() == 0) begin
                    chk("extra_valid", 64'(o_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("i_data", o_i_data, e.i);
                    chk("w_data", o_w_data, e.w);
                    chk("oob", 64'(o_oob), 64'(e.oob));
                end
            end
            if (o_done) begin
                done_cnt++;
                chk("done_with_last", 64'(exp_q.size()), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int sel, input int a, input logic [DW-1:0] d);
        sram_select = 2'(sel);
        write_addr  = 8'(a);
        data_in     = d;
        write_en    = 1'b1;
        tick();
        write_en    = 1'b0;
        if (sel == 0) mw[a] = d;
        if (sel == 1) mi[a] = d;
    endtask

    task automatic cfg(input int st, input int ie, input int is, input int os,
                       input int sd, input int ws, input int wo, input int rs);
        i_start = 8'(st); i_end = 8'(ie); i_size = 8'(is); o_size = 8'(os);
        stride = 8'(sd); w_start = 8'(ws); w_off = 8'(wo); route_size = 8'(rs);
    endtask

    task automatic model(input int st, input int ie, input int is, input int os,
                         input int sd, input int ws, input int wo, input int rs);
        int kk, a, wa;
        beat_t b;
        kk = is - (os - 1) * sd;
        for (int y = 0; y < os; y++)
            for (int x = 0; x < os; x++)
                for (int j = 0; j < rs; j++) begin
                    a  = (st + (y * sd + j / kk) * is + x * sd + j % kk) & 255;
                    wa = (ws + j * wo) & 255;
                    b.w = mw[wa];
                    b.i = mi[a];
                    b.oob = 1'b0;
`ifdef TOP_ADDR_CHECK_EN
                    if (a > ie) begin
                        b.i = '0;
                        b.oob = 1'b1;
                    end
`endif
                    exp_q.push_back(b);
                end
    endtask

    task automatic go();
        route_en = 1'b1;
        tick();
        route_en = 1'b0;
    endtask

    task automatic wait_done(input string name, input int n);
        int d0, i;
        d0 = done_cnt;
        i = 0;
        while (done_cnt == d0 && i < n) begin
            tick();
            i++;
        end
        chk(name, 64'(done_cnt - d0), 64'd1);
        repeat (3) tick();
    endtask

    task automatic restart();
        beats = 0;
        cap_i.delete();
        cap_w.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        int lastp[9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
        int d0, n;

        #12;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_oob", 64'(o_oob), 64'd0);
        chk("rst_i_data", o_i_data, 64'd0);
        chk("rst_w_data", o_w_data, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int a = 0; a < 25; a++) begin
            wr(0, a, word(a));
            wr(1, a, word(a));
        end

        restart();
        cfg(0, 255, 5, 3, 1, 0, 1, 9);
        model(0, 255, 5, 3, 1, 0, 1, 9);
        go();
        chk("a_busy", 64'(o_busy), 64'd1);
        wait_done("a_done", 200);
        chk("a_beats", 64'(beats), 64'd81);
        if (beats == 81)
            for (int j = 0; j < 9; j++) begin
                chk("a_first_i", cap_i[j], word(first[j]));
                chk("a_first_w", cap_w[j], word(j));
                chk("a_last_i", cap_i[72+j], word(lastp[j]));
            end

        restart();
        cfg(0, 255, 5, 2, 2, 0, 1, 9);
        model(0, 255, 5, 2, 2, 0, 1, 9);
        go();
        wait_done("b_done", 200);
        chk("b_beats", 64'(beats), 64'd36);
        if (beats == 36) begin
            chk("b_px01", cap_i[9], word(2));
            chk("b_px10", cap_i[18], word(10));
        end

        restart();
        cfg(0, 20, 5, 3, 1, 0, 1, 9);
        model(0, 20, 5, 3, 1, 0, 1, 9);
        go();
        wait_done("oob_done", 200);
        chk("oob_beats", 64'(beats), 64'd81);
        if (beats == 81)
            for (int j = 78; j < 81; j++)
`ifdef TOP_ADDR_CHECK_EN
                chk("oob_zero", cap_i[j], 64'd0);
`else
                chk("oob_raw", cap_i[j], word(j - 56));
`endif

        restart();
        cfg(0, 255, 5, 0, 1, 0, 1, 9);
        go();
        wait_done("zero_os_done", 10);
        cfg(0, 255, 5, 3, 1, 0, 1, 0);
        go();
        wait_done("zero_rs_done", 10);
        chk("zero_beats", 64'(beats), 64'd0);

        restart();
        cfg(0, 255, 5, 3, 1, 0, 1, 9);
        model(0, 255, 5, 3, 1, 0, 1, 9);
        go();
        n = 0;
        while (beats != 39 && n < 200) begin
            tick();
            n++;
        end
        chk("clr_reach", 64'(beats), 64'd39);
        reg_clear = 1'b1;
        d0 = done_cnt;
        tick();
        reg_clear = 1'b0;
        chk("clr_valid", 64'(o_valid), 64'd0);
        chk("clr_busy", 64'(o_busy), 64'd0);
        exp_q.delete();
        repeat (100) tick();
        chk("clr_no_done", 64'(done_cnt - d0), 64'd0);
        chk("clr_beats", 64'(beats), 64'd40);

        restart();
        cfg(0, 255, 3, 1, 1, 4, 1, 4);
        model(0, 255, 3, 1, 1, 4, 1, 4);
        route_en = 1'b1;
        wait_done("hold_done", 20);
        repeat (10) tick();
        chk("hold_beats", 64'(beats), 64'd4);
        chk("hold_busy", 64'(o_busy), 64'd0);
        route_en = 1'b0;
        tick();
        model(0, 255, 3, 1, 1, 4, 1, 4);
        go();
        wait_done("rearm_done", 20);
        chk("rearm_beats", 64'(beats), 64'd8);

        restart();
        cfg(0, 255, 5, 3, 1, 0, 1, 9);
        model(0, 255, 5, 3, 1, 0, 1, 9);
        go();
        repeat (20) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 64'(o_valid), 64'd0);
        chk("mrst_busy", 64'(o_busy), 64'd0);
        chk("mrst_done", 64'(o_done), 64'd0);
        chk("mrst_i_data", o_i_data, 64'd0);
        chk("mrst_w_data", o_w_data, 64'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        chk("mrst_idle", 64'(o_busy), 64'd0);
        restart();
        model(0, 255, 3, 1, 1, 4, 1, 4);
        cfg(0, 255, 3, 1, 1, 4, 1, 4);
        go();
        wait_done("mrst_route", 20);
        chk("mrst_beats", 64'(beats), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameters SHALL be: SRAM_DATA_WIDTH, default 64, word width; ADDR_WIDTH, default 8, address width, each SRAM depth 2**ADDR_WIDTH.
REQ-002 Ports SHALL be: i_clk  in  1  sole clock, rising edge.
REQ-003 i_nrst  in  1  reset, asynchronous, active-low.
REQ-004 i_reg_clear  in  1  synchronous clear of router state.
REQ-005 i_data_in  in  SRAM_DATA_WIDTH  write data.
REQ-006 i_write_addr  in  ADDR_WIDTH  write address.
REQ-007 i_sram_select  in  2  write target: 0 weight SRAM, 1 input SRAM, 2/3 no write.
REQ-008 i_write_en  in  1  write strobe.
REQ-009 i_route_en  in  1  route start request.
REQ-010 i_i_start_addr, i_i_addr_end, i_i_size, i_o_size, i_stride  in  ADDR_WIDTH each  input base, last valid input address, input width, output width, stride.
REQ-011 i_w_start_addr, i_w_addr_offset, i_route_size  in  ADDR_WIDTH each  weight base, weight address step, reads per output pixel (K*K).
REQ-012 o_i_data, o_w_data  out  SRAM_DATA_WIDTH  routed input/weight words.
REQ-013 o_valid  out  1  o_i_data/o_w_data valid this cycle.
REQ-014 o_busy  out  1  route in progress; o_done  out  1  one-cycle completion pulse; o_oob  out  1  current input beat out of range.

Function
REQ-015 Write: i_write_en high at a rising edge SHALL store i_data_in at i_write_addr in the SRAM chosen by i_sram_select; writes SHALL be accepted in any state.
REQ-016 States SHALL be IDLE, ROUTE, DONE.
REQ-017 IDLE->ROUTE when i_route_en=1 and armed; all configuration inputs SHALL be latched on that edge; K = i_size-(o_size-1)*stride computed once.
REQ-018 ROUTE: for oy, ox in 0..o_size-1 (ox fastest), for k in 0..route_size-1 with kr=k/K, kc=k%K (counters, no divider), one read pair per cycle: input addr = i_start + (oy*stride+kr)*i_size + (ox*stride+kc); weight addr = w_start + k*w_addr_offset.
REQ-019 All address arithmetic SHALL wrap modulo 2**ADDR_WIDTH.
REQ-020 Read latency SHALL be 1: address issued cycle t, data and o_valid=1 at t+1; o_valid SHALL assert exactly o_size*o_size*route_size times per route.
REQ-021 After the last issue, ROUTE->DONE; o_done SHALL pulse for one cycle coincident with the last o_valid; DONE->IDLE next cycle.
REQ-022 Re-arm: a new route SHALL require i_route_en to be low for at least one cycle after o_done.
REQ-023 Same-cycle write and read of one address SHALL return old data.
REQ-024 o_size=0 or route_size=0 SHALL complete immediately: o_done pulse, no o_valid.
REQ-025 i_reg_clear SHALL return state to IDLE, zero counters and outputs, suppress o_done; SRAM contents SHALL be kept; it overrides i_route_en in the same cycle.

Reset
REQ-026 i_nrst low SHALL asynchronously force IDLE, o_valid/o_done/o_busy/o_oob=0, o_i_data/o_w_data=0, disarm nothing (armed=1); SRAM contents undefined.

Configuration
REQ-027 Macro TOP_ADDR_CHECK_EN defined: input addresses > latched i_i_addr_end SHALL output o_i_data=0 and o_oob=1 for that beat; undefined: raw SRAM data, o_oob tied 0.

Structure
REQ-028 Package top_pkg SHALL hold SRAM_DATA_WIDTH, ADDR_WIDTH defaults and the state enum.
REQ-029 One sub-module sram_1w1r (sync write, registered read) SHALL be instantiated twice.

Verification
REQ-030 Reset mid-route -> all outputs 0 immediately, IDLE after release.
REQ-031 Fill both SRAMs word a = {8{a}} for a=0..24; i_size=5, o_size=3, stride=1, route_size=9, w_offset=1 -> first pixel input addrs 0,1,2,5,6,7,10,11,12, weight 0..8; last pixel 12,13,14,17,18,19,22,23,24; 81 o_valid, o_done with the 81st.
REQ-032 i_size=5, o_size=2, stride=2, route_size=9 -> pixel (0,1) starts at addr 2, pixel (1,0) at addr 10, 36 beats.
REQ-033 TOP_ADDR_CHECK_EN, i_i_addr_end=20, REQ-031 setup -> beats at addrs 22,23,24 give o_i_data=0, o_oob=1.
REQ-034 i_reg_clear pulse at beat 40 -> o_valid 0 next cycle, no o_done, o_busy 0.
REQ-035 i_route_en held high through o_done -> no second route until low then high.
